dual_ad_pre_adder: RTL and testbench
====================================

Name: dual_ad_pre_adder

Overview:
- A/D input stage of the DSP48E1-style slice.
- Selects the A operand from the fabric (A) or from the cascade (ACIN) and pipelines it through the A1/A2 registers.
- Drives the cascade output (ACOUT) and the X-mux A operand (X_MUX_A).
- Forms the 25-bit multiplier operand A_MULT, optionally through the D-port pre-adder/subtractor and the AD register.

Parameters:
- A_INPUT, "DIRECT": "DIRECT" uses A; "CASCADE" uses ACIN.
- AREG, 1: number of A pipeline registers (0, 1 or 2).
- ACASCREG, 1: number of A registers seen at ACOUT (0, 1 or 2); must be <= AREG.
- DREG, 1: number of D input registers (0 or 1).
- ADREG, 1: number of pre-adder output registers (0 or 1).
- USE_DPORT, "FALSE": "TRUE" enables the D port and the pre-adder.

Ports:
- CLK  in  1  rising-edge clock.
- RSTA  in  1  asynchronous active-low reset for A1/A2.
- RSTD  in  1  asynchronous active-low reset for the D and AD registers.
- A  in  30 signed  fabric A input.
- ACIN  in  30 signed  cascade A input.
- D  in  25 signed  pre-adder D input.
- INMODE_0TO3  in  4  operand control (unregistered).
- CEA1  in  1  clock enable for A1.
- CEA2  in  1  clock enable for A2.
- CED  in  1  clock enable for the D register.
- CEAD  in  1  clock enable for the AD register.
- A_MULT  out  25 signed  multiplier A operand.
- ACOUT  out  30 signed  A cascade output.
- X_MUX_A  out  30 signed  A operand to the X mux.

Behaviour:
- Clock and reset: single clock CLK. RSTA and RSTD are asynchronous and active-low. On assertion, the affected registers clear to 0 immediately. Reset overrides the clock enables.
- Input select: Ain = (A_INPUT=="DIRECT") ? A : ACIN.
- AREG=0: A1 and A2 are bypassed; A2out = A1out = Ain (combinational).
- AREG=1: only A2 is used (loaded from Ain when CEA2=1); A1out = Ain.
- AREG=2: A1 loads Ain when CEA1=1; A2 loads A1 when CEA2=1.
- X_MUX_A = A2out (latency AREG).
- ACOUT = A2out when ACASCREG==AREG. ACOUT = A1 register output when AREG=2 and ACASCREG=1 (latency 1).
- Multiplier A source: Amult_src = (AREG==2 && INMODE_0TO3[0]) ? A1 : A2out. This selection gives latency AREG-1 when the bit is set. A_gated = INMODE_0TO3[1] ? 0 : Amult_src[24:0].
- USE_DPORT="FALSE":
  - A_MULT = A_gated.
  - D, DREG, ADREG and INMODE_0TO3[3:2] are ignored; AD and D registers are not built.
- USE_DPORT="TRUE":
  - Dq = D delayed by DREG (loaded when CED=1).
  - D_gated = INMODE_0TO3[2] ? Dq : 0.
  - AD = INMODE_0TO3[3] ? D_gated - A_gated : D_gated + A_gated.
  - Arithmetic is 25-bit two's complement with wrap-around; no saturation, carry discarded.
  - ADREG=1: the AD register loads when CEAD=1 and A_MULT = AD register. ADREG=0: A_MULT = AD (combinational).
- Latency summary:
  - A_MULT latency is AREG+ADREG when the A path dominates, minus 1 when INMODE_0TO3[0] selects A1 with AREG=2.
  - With AREG=0 and ADREG=0, latency is DREG.
- Enables: a register with its enable at 0 holds its value.
- Legal parameter sets:
  - AREG=0 requires ACASCREG=0.
  - AREG=1 requires ACASCREG=1.
  - AREG=2 allows ACASCREG 1 or 2.
  - Other combinations are unsupported.
- Reset mid-operation: outputs fed from cleared registers read 0 at the next sample point. Pipeline refills normally after release.

Optional Feature:
- Macro DUAL_AD_PARAM_CHECK_EN.
- Defined:
  - Elaboration-time $fatal on an illegal AREG/ACASCREG/DREG/ADREG value or an illegal string parameter.
  - Simulation assertion: when neither reset is asserted, INMODE_0TO3 must not be X/Z at a clock edge.
- Undefined: no checks; behaviour with illegal parameters is unspecified.

Test Plan:
- Reset: assert RSTA=0 with AREG=2 -> ACOUT=0 and X_MUX_A=0 immediately. Assert RSTD=0 with USE_DPORT="TRUE", ADREG=1 -> A_MULT=0.
- A pipeline: A_INPUT="CASCADE", AREG=2, ACASCREG=1, ACIN=30'h0ABCDEF1, all CE=1 -> ACOUT=ACIN after 1 edge; X_MUX_A=ACIN after 2 edges.
- INMODE A-select/gate: USE_DPORT="FALSE", AREG=2, INMODE=4'b0001 -> A_MULT=ACIN[24:0] after 1 edge. INMODE=4'b0010 -> A_MULT=0.
- Pre-adder: USE_DPORT="TRUE", DIRECT, AREG=1, DREG=1, ADREG=1, A=25'h0000005, D=25'h0000003:
  - INMODE=4'b0100 -> A_MULT=8 after 2 edges.
  - INMODE=4'b1100 -> A_MULT=-2.
  - INMODE=4'b1000 -> A_MULT=-5.
  - INMODE=4'b0110 -> A_MULT=3.
- Wrap: D=25'h0FFFFFF, A=1, INMODE=4'b0100 -> A_MULT=25'h1000000.
- Clock enable hold: drive CEA1=CEA2=0 while changing A -> X_MUX_A, ACOUT and A_MULT unchanged. Randomized sweep of 2000 vectors over all INMODE codes with zero mismatches.

Source files
------------

// File: rtl/dual_ad_pre_adder_if.sv
// Operand/control bundle for the A/D input stage: fabric, cascade and D inputs,
// unregistered INMODE bits, clock enables and the three operand outputs.
interface dual_ad_pre_adder_if;
   logic signed [29:0] A;
   logic signed [29:0] ACIN;
   logic signed [24:0] D;
   logic        [3:0]  INMODE_0TO3;
   logic               CEA1;
   logic               CEA2;
   logic               CED;
   logic               CEAD;
   logic signed [24:0] A_MULT;
   logic signed [29:0] ACOUT;
   logic signed [29:0] X_MUX_A;

   modport master (
      output A, ACIN, D, INMODE_0TO3, CEA1, CEA2, CED, CEAD,
      input  A_MULT, ACOUT, X_MUX_A
   );

   modport slave (
      input  A, ACIN, D, INMODE_0TO3, CEA1, CEA2, CED, CEAD,
      output A_MULT, ACOUT, X_MUX_A
   );
endinterface

// File: rtl/dual_ad_pre_adder.sv
// A/D input stage of a DSP48E1-style slice: A1/A2 pipeline, cascade output and
// optional D pre-adder. Defining DUAL_AD_PARAM_CHECK_EN adds parameter and INMODE checks.
module dual_ad_pre_adder #(
   parameter string A_INPUT   = "DIRECT",
   parameter int    AREG      = 1,
   parameter int    ACASCREG  = 1,
   parameter int    DREG      = 1,
   parameter int    ADREG     = 1,
   parameter string USE_DPORT = "FALSE"
) (
   input logic                CLK,
   input logic                RSTA,
   input logic                RSTD,
   dual_ad_pre_adder_if.slave bus
);

   localparam bit CASCADE_SEL = (A_INPUT == "CASCADE");
   localparam bit DPORT_EN    = (USE_DPORT == "TRUE");

   logic signed [29:0] a_in_s;
   logic signed [29:0] a1_out_s;
   logic signed [29:0] a2_out_s;
   logic signed [24:0] amult_src_s;
   logic signed [24:0] a_gated_s;

   assign a_in_s = CASCADE_SEL ? bus.ACIN : bus.A;

   if (AREG == 2) begin : g_a1
      logic signed [29:0] a1_r;
      // A1 stage, only present in the two-register A pipeline
      always_ff @(posedge CLK or negedge RSTA) begin
         if (!RSTA) begin
            a1_r <= 30'sd0;
         end else if (bus.CEA1) begin
            a1_r <= a_in_s;
         end
      end
      assign a1_out_s = a1_r;
   end else begin : g_a1_bypass
      assign a1_out_s = a_in_s;
   end

   if (AREG == 0) begin : g_a2_bypass
      assign a2_out_s = a1_out_s;
   end else begin : g_a2
      logic signed [29:0] a2_r;
      // A2 stage, fed by A1 when it exists and directly by the selected input otherwise
      always_ff @(posedge CLK or negedge RSTA) begin
         if (!RSTA) begin
            a2_r <= 30'sd0;
         end else if (bus.CEA2) begin
            a2_r <= a1_out_s;
         end
      end
      assign a2_out_s = a2_r;
   end

   assign bus.X_MUX_A = a2_out_s;
   assign bus.ACOUT   = (ACASCREG == AREG) ? a2_out_s : a1_out_s;

   if (AREG == 2) begin : g_amult_sel
      // INMODE[0] lets the multiplier take A1, saving one cycle of latency
      always_comb begin
         amult_src_s = a2_out_s[24:0];
         if (bus.INMODE_0TO3[0]) begin
            amult_src_s = a1_out_s[24:0];
         end else begin
            amult_src_s = a2_out_s[24:0];
         end
      end
   end else begin : g_amult_a2
      assign amult_src_s = a2_out_s[24:0];
   end

   assign a_gated_s = bus.INMODE_0TO3[1] ? 25'sd0 : amult_src_s;

   if (DPORT_EN) begin : g_dport
      logic signed [24:0] dq_s;
      logic signed [24:0] d_gated_s;
      logic signed [24:0] ad_s;

      if (DREG == 1) begin : g_dreg
         logic signed [24:0] d_r;
         // D input register
         always_ff @(posedge CLK or negedge RSTD) begin
            if (!RSTD) begin
               d_r <= 25'sd0;
            end else if (bus.CED) begin
               d_r <= bus.D;
            end
         end
         assign dq_s = d_r;
      end else begin : g_dreg_bypass
         assign dq_s = bus.D;
      end

      // Pre-adder/subtractor, 25-bit wrap-around with carry discarded
      always_comb begin
         d_gated_s = 25'sd0;
         ad_s      = 25'sd0;
         if (bus.INMODE_0TO3[2]) begin
            d_gated_s = dq_s;
         end else begin
            d_gated_s = 25'sd0;
         end
         if (bus.INMODE_0TO3[3]) begin
            ad_s = d_gated_s - a_gated_s;
         end else begin
            ad_s = d_gated_s + a_gated_s;
         end
      end

      if (ADREG == 1) begin : g_adreg
         logic signed [24:0] ad_r;
         // AD register on the pre-adder output
         always_ff @(posedge CLK or negedge RSTD) begin
            if (!RSTD) begin
               ad_r <= 25'sd0;
            end else if (bus.CEAD) begin
               ad_r <= ad_s;
            end
         end
         assign bus.A_MULT = ad_r;
      end else begin : g_adreg_bypass
         assign bus.A_MULT = ad_s;
      end
   end else begin : g_no_dport
      assign bus.A_MULT = a_gated_s;
   end

`ifdef DUAL_AD_PARAM_CHECK_EN
   localparam bit PARAMS_OK =
      ((A_INPUT == "DIRECT") || (A_INPUT == "CASCADE")) &&
      ((USE_DPORT == "TRUE") || (USE_DPORT == "FALSE")) &&
      ((DREG == 0) || (DREG == 1)) &&
      ((ADREG == 0) || (ADREG == 1)) &&
      (((AREG == 0) && (ACASCREG == 0)) ||
       ((AREG == 1) && (ACASCREG == 1)) ||
       ((AREG == 2) && ((ACASCREG == 1) || (ACASCREG == 2))));

   if (!PARAMS_OK) begin : g_param_err
      $fatal(1, "dual_ad_pre_adder: illegal parameter combination");
   end

   dual_ad_pre_adder_chk u_chk (
      .CLK    (CLK),
      .RSTA   (RSTA),
      .RSTD   (RSTD),
      .inmode (bus.INMODE_0TO3)
   );
`endif

endmodule

`ifdef DUAL_AD_PARAM_CHECK_EN
module dual_ad_pre_adder_chk (
   input logic       CLK,
   input logic       RSTA,
   input logic       RSTD,
   input logic [3:0] inmode
);
   a_inmode_known: assert property (@(posedge CLK) disable iff (!(RSTA && RSTD)) !$isunknown(inmode))
      else $error("dual_ad_pre_adder: INMODE_0TO3 unknown at clock edge");
endmodule
`endif

// File: tb/tb_dual_ad_pre_adder.sv
// Bench for dual_ad_pre_adder: three configurations driven in lockstep, directed
// cases followed by a random sweep checked against a latency-history model.
module tb_dual_ad_pre_adder;

   localparam int NVEC = 2000;

   logic clk = 1'b0;
   logic rsta;
   logic rstd;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   dual_ad_pre_adder_if bus_c ();
   dual_ad_pre_adder_if bus_p ();
   dual_ad_pre_adder_if bus_z ();

   dual_ad_pre_adder #(.A_INPUT("CASCADE"), .AREG(2), .ACASCREG(1), .DREG(1), .ADREG(1),
                       .USE_DPORT("FALSE"))
      dut_c (.CLK(clk), .RSTA(rsta), .RSTD(rstd), .bus(bus_c));

   dual_ad_pre_adder #(.A_INPUT("DIRECT"), .AREG(1), .ACASCREG(1), .DREG(1), .ADREG(1),
                       .USE_DPORT("TRUE"))
      dut_p (.CLK(clk), .RSTA(rsta), .RSTD(rstd), .bus(bus_p));

   dual_ad_pre_adder #(.A_INPUT("DIRECT"), .AREG(0), .ACASCREG(0), .DREG(1), .ADREG(0),
                       .USE_DPORT("TRUE"))
      dut_z (.CLK(clk), .RSTA(rsta), .RSTD(rstd), .bus(bus_z));

   logic [29:0] ha [0:NVEC-1];
   logic [29:0] hc [0:NVEC-1];
   logic [24:0] hd [0:NVEC-1];
   logic [3:0]  hi [0:NVEC-1];

   task automatic check_val(input string tag, input logic [29:0] obs, input logic [29:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [29:0] a, input logic [29:0] acin, input logic [24:0] d,
                        input logic [3:0] inm);
      bus_c.A = a; bus_c.ACIN = acin; bus_c.D = d; bus_c.INMODE_0TO3 = inm;
      bus_p.A = a; bus_p.ACIN = acin; bus_p.D = d; bus_p.INMODE_0TO3 = inm;
      bus_z.A = a; bus_z.ACIN = acin; bus_z.D = d; bus_z.INMODE_0TO3 = inm;
   endtask

   task automatic set_ce(input logic cea1, input logic cea2, input logic ced, input logic cead);
      bus_c.CEA1 = cea1; bus_c.CEA2 = cea2; bus_c.CED = ced; bus_c.CEAD = cead;
      bus_p.CEA1 = cea1; bus_p.CEA2 = cea2; bus_p.CED = ced; bus_p.CEAD = cead;
      bus_z.CEA1 = cea1; bus_z.CEA2 = cea2; bus_z.CED = ced; bus_z.CEAD = cead;
   endtask

   // Advance past n rising edges and stop 2 time units after the last one.
   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
      end
      #2;
   endtask

   function automatic logic signed [24:0] pre(input logic [3:0] inm, input logic signed [24:0] a,
                                               input logic signed [24:0] d);
      logic signed [24:0] ag;
      logic signed [24:0] dg;
      ag = inm[1] ? 25'sd0 : a;
      dg = inm[2] ? d : 25'sd0;
      return inm[3] ? (dg - ag) : (dg + ag);
   endfunction

   logic signed [24:0] em;
   logic signed [24:0] om;
   logic        [29:0] src;

   initial begin
      rsta = 1'b0;
      rstd = 1'b0;
      set_ce(1'b1, 1'b1, 1'b1, 1'b1);
      drive(30'd0, 30'd0, 25'd0, 4'b0000);
      ticks(3);
      check_val("rst_c_x", bus_c.X_MUX_A, 30'd0);
      check_val("rst_c_acout", bus_c.ACOUT, 30'd0);
      em = 25'sd0; om = bus_p.A_MULT;
      check_val("rst_p_amult", om, em);
      rsta = 1'b1;
      rstd = 1'b1;

      // Cascade pipeline and A1 select
      drive(30'h0000005, 30'h0ABCDEF1, 25'd3, 4'b0001);
      ticks(1);
      check_val("pipe_acout_1edge", bus_c.ACOUT, 30'h0ABCDEF1);
      check_val("pipe_x_1edge", bus_c.X_MUX_A, 30'd0);
      em = 25'h0BCDEF1; om = bus_c.A_MULT;
      check_val("inm0001_amult", om, em);
      ticks(1);
      check_val("pipe_x_2edge", bus_c.X_MUX_A, 30'h0ABCDEF1);
      drive(30'h0000005, 30'h0ABCDEF1, 25'd3, 4'b0010);
      #1;
      em = 25'sd0; om = bus_c.A_MULT;
      check_val("inm0010_gate", om, em);

      // RSTA clears A registers at once
      #1;
      rsta = 1'b0;
      #1;
      check_val("rsta_c_acout", bus_c.ACOUT, 30'd0);
      check_val("rsta_c_x", bus_c.X_MUX_A, 30'd0);
      check_val("rsta_p_x", bus_p.X_MUX_A, 30'd0);
      rsta = 1'b1;

      // Pre-adder steady-state results, also seen through the combinational variant
      drive(30'h0000005, 30'h0000005, 25'd3, 4'b0100);
      ticks(3);
      em = 25'sd8; om = bus_p.A_MULT; check_val("pre_0100_p", om, em);
      om = bus_z.A_MULT; check_val("pre_0100_z", om, em);
      rstd = 1'b0;
      #1;
      em = 25'sd0; om = bus_p.A_MULT; check_val("rstd_p_amult", om, em);
      rstd = 1'b1;
      ticks(2);
      em = 25'sd8; om = bus_p.A_MULT; check_val("rstd_refill", om, em);
      drive(30'h0000005, 30'h0000005, 25'd3, 4'b1100);
      ticks(2);
      em = -25'sd2; om = bus_p.A_MULT; check_val("pre_1100_p", om, em);
      om = bus_z.A_MULT; check_val("pre_1100_z", om, em);
      drive(30'h0000005, 30'h0000005, 25'd3, 4'b1000);
      ticks(2);
      em = -25'sd5; om = bus_p.A_MULT; check_val("pre_1000_p", om, em);
      drive(30'h0000005, 30'h0000005, 25'd3, 4'b0110);
      ticks(2);
      em = 25'sd3; om = bus_p.A_MULT; check_val("pre_0110_p", om, em);
      drive(30'h0000001, 30'h0000001, 25'h0FFFFFF, 4'b0100);
      ticks(3);
      em = 25'h1000000; om = bus_p.A_MULT; check_val("wrap_p", om, em);
      om = bus_z.A_MULT; check_val("wrap_z", om, em);

      // A clock-enable hold
      drive(30'h1234567, 30'h1234567, 25'd3, 4'b0100);
      ticks(3);
      set_ce(1'b0, 1'b0, 1'b1, 1'b1);
      drive(30'h3000ABC, 30'h3000ABC, 25'd3, 4'b0100);
      ticks(3);
      check_val("hold_c_x", bus_c.X_MUX_A, 30'h1234567);
      check_val("hold_c_acout", bus_c.ACOUT, 30'h1234567);
      em = 25'h1234567; om = bus_c.A_MULT; check_val("hold_c_amult", om, em);
      check_val("hold_p_x", bus_p.X_MUX_A, 30'h1234567);
      em = 25'h123456A; om = bus_p.A_MULT; check_val("hold_p_amult", om, em);

      // D and AD clock-enable hold
      set_ce(1'b1, 1'b1, 1'b1, 1'b1);
      drive(30'h0000010, 30'h0000010, 25'd3, 4'b0100);
      ticks(3);
      set_ce(1'b1, 1'b1, 1'b0, 1'b1);
      drive(30'h0000010, 30'h0000010, 25'h0000100, 4'b0100);
      ticks(3);
      em = 25'h13; om = bus_p.A_MULT; check_val("hold_ced", om, em);
      set_ce(1'b1, 1'b1, 1'b1, 1'b0);
      ticks(3);
      om = bus_p.A_MULT; check_val("hold_cead", om, em);
      set_ce(1'b1, 1'b1, 1'b1, 1'b1);
      ticks(1);
      em = 25'h110; om = bus_p.A_MULT; check_val("release_cead", om, em);

      // Random sweep: outputs predicted from input history and each path's latency
      for (int i = 0; i < NVEC; i++) begin
         ha[i] = 30'($urandom);
         hc[i] = 30'($urandom);
         hd[i] = 25'($urandom);
         hi[i] = 4'($urandom_range(15, 0));
         drive(ha[i], hc[i], hd[i], hi[i]);
         #1;
         if (i >= 2) begin
            check_val("rnd_c_x", bus_c.X_MUX_A, hc[i-2]);
            check_val("rnd_c_acout", bus_c.ACOUT, hc[i-1]);
            src = hi[i][0] ? hc[i-1] : hc[i-2];
            em = hi[i][1] ? 25'sd0 : src[24:0];
            om = bus_c.A_MULT; check_val("rnd_c_amult", om, em);
            check_val("rnd_p_x", bus_p.X_MUX_A, ha[i-1]);
            check_val("rnd_p_acout", bus_p.ACOUT, ha[i-1]);
            em = pre(hi[i-1], ha[i-2][24:0], hd[i-2]);
            om = bus_p.A_MULT; check_val("rnd_p_amult", om, em);
            check_val("rnd_z_x", bus_z.X_MUX_A, ha[i]);
            check_val("rnd_z_acout", bus_z.ACOUT, ha[i]);
            em = pre(hi[i], ha[i][24:0], hd[i-1]);
            om = bus_z.A_MULT; check_val("rnd_z_amult", om, em);
         end
         @(posedge clk);
         #2;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
